// File: rtl/jt49_mix_pkg.sv
// Shared types and constants for the three-channel PSG mixer.
// The linear table uses 1.5 dB steps from full scale, and entry 0 is silent.
package jt49_mix_pkg;

    localparam int VOLW = 5;
    localparam int ACCW = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_RD_C,
        ST_ADD_C,
        ST_SCALE
    } state_t;

    localparam logic [7:0] LIN_TBL [0:31] = '{
        8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
        8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
        8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
        8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
    };

endpackage

// File: rtl/jt49_mix_lut.sv
// Registered log-to-linear ROM.
// Data appears one clock after the address is presented.
module jt49_mix_lut
    import jt49_mix_pkg::*;
(
    input  logic            clk,
    input  logic [VOLW-1:0] addr,
    output logic [7:0]      q
);

    logic [7:0] q_d;
    logic [7:0] q_q;

    always_comb begin
        q_d = LIN_TBL[addr];
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/jt49_mix3.sv
// Time-multiplexed three-channel mixer feeding the DC-removal filter.
// One shared LUT is walked A, B, C, then the sum is scaled and saturated.
module jt49_mix3
    import jt49_mix_pkg::*;
#(
    parameter logic [3:0] GAIN = 4'd5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [VOLW-1:0] vol_a,
    input  logic [VOLW-1:0] vol_b,
    input  logic [VOLW-1:0] vol_c,
    input  logic [2:0]      ch_en,
    output logic [7:0]      dout,
    output logic            dout_stb,
    output logic            overrun
);

    state_t          state_q, state_d;
    logic [VOLW-1:0] va_q, va_d, vb_q, vb_d, vc_q, vc_d;
    logic [2:0]      en_q, en_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [7:0]      dout_q, dout_d;
    logic            stb_q, stb_d;
    logic            ovr_q, ovr_d;

    logic [VOLW-1:0] lut_addr;
    logic [7:0]      lut_q;
    logic [7:0]      lin;
    logic [13:0]     prod;
    logic [9:0]      scaled;

    jt49_mix_lut u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .q    (lut_q)
    );

    // The LUT output lags the address by one state, so the enable bit is chosen for the channel addressed one state earlier.
    always_comb begin
        lin = 8'd0;
        case (state_q)
            ST_RD_B:  lin = en_q[0] ? lut_q : 8'd0;
            ST_RD_C:  lin = en_q[1] ? lut_q : 8'd0;
            ST_ADD_C: lin = en_q[2] ? lut_q : 8'd0;
            default:  lin = 8'd0;
        endcase
    end

    always_comb begin
        prod   = 14'(acc_q) * 14'(GAIN);
        scaled = prod[13:4];
    end

    always_comb begin
        state_d  = state_q;
        va_d     = va_q;
        vb_d     = vb_q;
        vc_d     = vc_q;
        en_d     = en_q;
        acc_d    = acc_q;
        dout_d   = dout_q;
        stb_d    = 1'b0;
        ovr_d    = ovr_q;
        lut_addr = va_q;

        if (cen && state_q != ST_IDLE) ovr_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (cen) begin
                    va_d    = vol_a;
                    vb_d    = vol_b;
                    vc_d    = vol_c;
                    en_d    = ch_en;
                    state_d = ST_RD_A;
                end
            end
            ST_RD_A: begin
                lut_addr = va_q;
                acc_d    = '0;
                state_d  = ST_RD_B;
            end
            ST_RD_B: begin
                lut_addr = vb_q;
                acc_d    = acc_q + ACCW'(lin);
                state_d  = ST_RD_C;
            end
            ST_RD_C: begin
                lut_addr = vc_q;
                acc_d    = acc_q + ACCW'(lin);
                state_d  = ST_ADD_C;
            end
            ST_ADD_C: begin
                acc_d   = acc_q + ACCW'(lin);
                state_d = ST_SCALE;
            end
            ST_SCALE: begin
                dout_d  = (scaled > 10'd255) ? 8'hFF : scaled[7:0];
                stb_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            va_q    <= '0;
            vb_q    <= '0;
            vc_q    <= '0;
            en_q    <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            stb_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
            vc_q    <= vc_d;
            en_q    <= en_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            stb_q   <= stb_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout     = dout_q;
    assign dout_stb = stb_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_jt49_mix3.sv
// Self-checking bench for jt49_mix3. Three instances run with GAIN 5, 8 and 0 on shared stimulus.
// The expected values come from the decibel formula evaluated in real arithmetic.
module tb_jt49_mix3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic [4:0] va, vb, vc;
    logic [2:0] ch_en;
    logic [7:0] dout_w [3];
    logic       stb_w  [3];
    logic       ovr_w  [3];

    int gains [3] = '{5, 8, 0};
    int lin_ref [32];
    int checks = 0;
    int errors = 0;
    bit ovr_exp = 1'b0;

    always #5 clk = ~clk;

    jt49_mix3 #(.GAIN(4'd5)) dut_g5 (
        .clk(clk), .rst(rst), .cen(cen), .vol_a(va), .vol_b(vb), .vol_c(vc),
        .ch_en(ch_en), .dout(dout_w[0]), .dout_stb(stb_w[0]), .overrun(ovr_w[0]));
    jt49_mix3 #(.GAIN(4'd8)) dut_g8 (
        .clk(clk), .rst(rst), .cen(cen), .vol_a(va), .vol_b(vb), .vol_c(vc),
        .ch_en(ch_en), .dout(dout_w[1]), .dout_stb(stb_w[1]), .overrun(ovr_w[1]));
    jt49_mix3 #(.GAIN(4'd0)) dut_g0 (
        .clk(clk), .rst(rst), .cen(cen), .vol_a(va), .vol_b(vb), .vol_c(vc),
        .ch_en(ch_en), .dout(dout_w[2]), .dout_stb(stb_w[2]), .overrun(ovr_w[2]));

    function automatic int model(input int a, input int b, input int c,
                                 input logic [2:0] en, input int g);
        int acc, q;
        acc = 0;
        if (en[0]) acc += lin_ref[a];
        if (en[1]) acc += lin_ref[b];
        if (en[2]) acc += lin_ref[c];
        q = (acc * g) / 16;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample starting at E0. inj>0 pulses cen while busy, at edge E(inj+1).
    // hold keeps cen high throughout. scr scrambles the inputs right after E0.
    task automatic run_sample(input int a, input int b, input int c, input logic [2:0] en,
                              input int inj, input bit hold, input bit scr);
        int exp_d [3];
        for (int k = 0; k < 3; k++) exp_d[k] = model(a, b, c, en, gains[k]);
        va = 5'(a); vb = 5'(b); vc = 5'(c); ch_en = en; cen = 1'b1;
        tick();
        if (!hold) cen = 1'b0;
        if (scr) begin
            va = 5'($urandom); vb = 5'($urandom); vc = 5'($urandom); ch_en = 3'($urandom);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (stb_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL stb_at_e0 dut%0d: got %0b expected 0", k, stb_w[k]);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            if (inj != 0 && i == inj + 1) cen = 1'b1;
            tick();
            if (hold) ovr_exp = 1'b1;
            if (inj != 0 && i == inj + 1) begin
                ovr_exp = 1'b1;
                cen = hold;
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (stb_w[k] !== (i == 5)) begin
                    errors++;
                    $display("FAIL stb_e%0d dut%0d: got %0b expected %0b", i, k, stb_w[k], (i == 5));
                end
                checks++;
                if (ovr_w[k] !== ovr_exp) begin
                    errors++;
                    $display("FAIL overrun_e%0d dut%0d: got %0b expected %0b", i, k, ovr_w[k], ovr_exp);
                end
                if (i == 5) begin
                    checks++;
                    if (dout_w[k] !== 8'(exp_d[k])) begin
                        errors++;
                        $display("FAIL dout dut%0d vols=%0d/%0d/%0d en=%b: got %0d expected %0d",
                                 k, a, b, c, en, dout_w[k], exp_d[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        cen = 1'b0; rst = 1'b1;
        va = 5'($urandom); vb = 5'($urandom); vc = 5'($urandom); ch_en = 3'($urandom);
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout_w[k] !== 8'd0 || stb_w[k] !== 1'b0 || ovr_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got dout=%0d stb=%0b ovr=%0b expected 0/0/0",
                         k, dout_w[k], stb_w[k], ovr_w[k]);
            end
        end
        rst = 1'b0;
        ovr_exp = 1'b0;
        tick();
    endtask

    task automatic test_single();
        run_sample(31, 0, 0, 3'b111, 0, 0, 0);
        checks++;
        if (dout_w[0] !== 8'd79) begin
            errors++;
            $display("FAIL single_a got %0d expected 79", dout_w[0]);
        end
        tick();
        checks++;
        if (stb_w[0] !== 1'b0 || dout_w[0] !== 8'd79) begin
            errors++;
            $display("FAIL stb_width got stb=%0b dout=%0d expected 0/79", stb_w[0], dout_w[0]);
        end
    endtask

    task automatic test_saturate();
        run_sample(31, 31, 31, 3'b111, 0, 0, 0);
        checks++;
        if (dout_w[0] !== 8'd239 || dout_w[1] !== 8'd255 || dout_w[2] !== 8'd0) begin
            errors++;
            $display("FAIL saturate got %0d/%0d/%0d expected 239/255/0", dout_w[0], dout_w[1], dout_w[2]);
        end
        tick();
    endtask

    task automatic test_enable();
        run_sample(31, 31, 31, 3'b000, 0, 0, 0);
        checks++;
        if (dout_w[0] !== 8'd0) begin
            errors++;
            $display("FAIL all_disabled got %0d expected 0", dout_w[0]);
        end
        tick();
        run_sample(31, 29, 31, 3'b010, 0, 0, 0);
        checks++;
        if (dout_w[0] !== 8'd56) begin
            errors++;
            $display("FAIL only_b got %0d expected 56", dout_w[0]);
        end
        tick();
        run_sample(7, 12, 31, 3'b100, 0, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++)
            run_sample($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                       3'($urandom), 0, 0, 1);
        tick();
    endtask

    task automatic test_overrun();
        run_sample(31, 20, 10, 3'b111, 2, 0, 0);
        tick(); tick();
        run_sample(25, 25, 25, 3'b101, 0, 0, 0);
        tick();
    endtask

    task automatic test_hold();
        for (int n = 0; n < 4; n++)
            run_sample($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                       3'($urandom), 0, 1, 0);
        cen = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid();
        va = 5'd31; vb = 5'd31; vc = 5'd31; ch_en = 3'b111; cen = 1'b1;
        tick();
        cen = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ovr_exp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout_w[k] !== 8'd0 || stb_w[k] !== 1'b0 || ovr_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid dut%0d: got dout=%0d stb=%0b ovr=%0b expected 0/0/0",
                         k, dout_w[k], stb_w[k], ovr_w[k]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (stb_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stb cycle %0d: got %0b expected 0", i, stb_w[0]);
            end
        end
        run_sample(30, 18, 24, 3'b111, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_sample($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                       3'($urandom), inj, 0, 1);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                va = 5'($urandom); vb = 5'($urandom); vc = 5'($urandom);
                tick();
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 32; n++)
            lin_ref[n] = (n == 0) ? 0 : $rtoi(255.0 * (10.0 ** (-(31 - n) * 0.075)) + 0.5);
        rst = 1'b1; cen = 1'b0;
        va = '0; vb = '0; vc = '0; ch_en = '0;
        test_reset();
        test_single();
        test_saturate();
        test_enable();
        test_back_to_back();
        test_overrun();
        test_hold();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
